// File: rtl/i_ref_pkg.sv
// Shared types and constants for the I_REF setup sequencer.
package i_ref_pkg;

   localparam int unsigned DEFAULT_BUS_WIDTH = 10;
   localparam logic [DEFAULT_BUS_WIDTH-1:0] I_REF_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE,
      FAIL
   } i_ref_seq_state_t;

   typedef enum logic {
      COARSE,
      FINE
   } i_ref_phase_t;

endpackage

// File: rtl/i_ref_setup_seq_if.sv
// Handshake/result bundle between the sequencer and the analog front end / I_REF mux.
interface i_ref_setup_seq_if #(
   parameter int unsigned BUS_WIDTH = i_ref_pkg::DEFAULT_BUS_WIDTH
);
   logic                 start;
   logic                 cmp_above;
   logic [BUS_WIDTH-1:0] i_ref_setup;
   logic                 completed;
   logic                 busy;
   logic                 fail;

   modport master (
      output start,
      output cmp_above,
      input  i_ref_setup,
      input  completed,
      input  busy,
      input  fail
   );

   modport slave (
      input  start,
      input  cmp_above,
      output i_ref_setup,
      output completed,
      output busy,
      output fail
   );
endinterface

// File: rtl/settle_timer.sv
// Load/expire down-counter that paces DAC/comparator settling after each code change.
module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);
   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
   // Expiry is seen combinationally on the last settle cycle, so load one less.
   localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= LOAD_VAL;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expired = (count_q == '0);
endmodule

// File: rtl/i_ref_setup_seq.sv
// Coarse/fine linear search for the highest I_REF code whose current is at or below target.
module i_ref_setup_seq
   import i_ref_pkg::*;
#(
   parameter int unsigned BUS_WIDTH     = DEFAULT_BUS_WIDTH,
   parameter int unsigned COARSE_STEP   = 32,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input logic              clk,
   input logic              rst,
   i_ref_setup_seq_if.slave bus
);
   localparam logic [BUS_WIDTH-1:0] MAX         = '1;
   localparam logic [BUS_WIDTH:0]   STEP_COARSE = (BUS_WIDTH + 1)'(COARSE_STEP);
   localparam logic [BUS_WIDTH:0]   STEP_FINE   = (BUS_WIDTH + 1)'(1);

   i_ref_seq_state_t     state_q, state_d;
   i_ref_phase_t         phase_q, phase_d;
   logic                 first_q, first_d;
   logic [BUS_WIDTH-1:0] code_q, code_d;
   logic                 tmr_load, tmr_expired;

   logic [BUS_WIDTH:0]   step, diff, sum;
   logic [BUS_WIDTH-1:0] dec_code, inc_code;
   logic                 code_zero;

   // One extra bit catches borrow/carry so the code clamps instead of wrapping.
   always_comb begin
      step      = (phase_q == COARSE) ? STEP_COARSE : STEP_FINE;
      diff      = {1'b0, code_q} - step;
      sum       = {1'b0, code_q} + STEP_COARSE;
      dec_code  = diff[BUS_WIDTH] ? '0 : diff[BUS_WIDTH-1:0];
      inc_code  = (sum > {1'b0, MAX}) ? MAX : sum[BUS_WIDTH-1:0];
      code_zero = (code_q == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= COARSE;
         first_q <= 1'b0;
         code_q  <= MAX;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         first_q <= first_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      first_d  = first_q;
      code_d   = code_q;
      tmr_load = 1'b0;
      unique case (state_q)
         IDLE, DONE, FAIL: begin
            if (bus.start) begin
               state_d  = SETTLE;
               phase_d  = COARSE;
               first_d  = 1'b1;
               code_d   = MAX;
               tmr_load = 1'b1;
            end
         end
         SETTLE: begin
            if (tmr_expired) state_d = SAMPLE;
         end
         SAMPLE: begin
            if (phase_q == COARSE) begin
               first_d = 1'b0;
               if (!bus.cmp_above && first_q) begin
                  state_d = FAIL;
               end else if (bus.cmp_above && code_zero) begin
                  state_d = FAIL;
                  code_d  = '0;
               end else if (bus.cmp_above) begin
                  state_d  = SETTLE;
                  code_d   = dec_code;
                  tmr_load = 1'b1;
               end else begin
                  // Overshot: back off one coarse step and walk down by ones.
                  state_d  = SETTLE;
                  code_d   = inc_code;
                  phase_d  = FINE;
                  tmr_load = 1'b1;
               end
            end else begin
               if (bus.cmp_above && code_zero) begin
                  state_d = FAIL;
               end else if (bus.cmp_above) begin
                  state_d  = SETTLE;
                  code_d   = dec_code;
                  tmr_load = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .en      (state_q == SETTLE),
      .expired (tmr_expired)
   );

   assign bus.i_ref_setup = code_q;
   assign bus.completed   = (state_q == DONE);
   assign bus.busy        = (state_q == SETTLE) || (state_q == SAMPLE);
   assign bus.fail        = (state_q == FAIL);
endmodule

// File: tb/tb_i_ref_setup_seq.sv
// Self-checking bench: comparator model plus a queue of expected codes under test.
module tb_i_ref_setup_seq;
   import i_ref_pkg::*;

   localparam int MAXC   = 1023;
   localparam int STEP   = 32;
   localparam int SETTLE = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   i_ref_setup_seq_if #(.BUS_WIDTH(10)) bus ();

   i_ref_setup_seq #(
      .BUS_WIDTH     (10),
      .COARSE_STEP   (STEP),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int target;
   bit tie_high;
   int errors = 0;
   int checks = 0;
   int exp_q[$];

   // Analog comparator model: current above target when code exceeds target.
   assign bus.cmp_above = tie_high || (int'(bus.i_ref_setup) > target);

   // Build the sequence of codes the search should visit, one entry per sample.
   task automatic push_expected();
      int c = MAXC;
      bit fine = 0;
      bit first = 1;
      bit above;
      exp_q.delete();
      for (int n = 0; n < 5000; n++) begin
         exp_q.push_back(c);
         above = tie_high || (c > target);
         if (!fine) begin
            if (!above && first) break;
            first = 0;
            if (above && c == 0) break;
            if (above) c = (c >= STEP) ? c - STEP : 0;
            else begin
               c    = (c + STEP > MAXC) ? MAXC : c + STEP;
               fine = 1;
            end
         end else begin
            if (!above || c == 0) break;
            c = c - 1;
         end
      end
   endtask

   task automatic run_search(input string name, input int ign_at, input int rst_at,
                             input bit exp_done, input int exp_code);
      int  c;
      int  err0 = errors;
      bit  aborted = 0;
      push_expected();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      while (exp_q.size() > 0 && !aborted) begin
         c = exp_q.pop_front();
         for (int k = 0; k <= SETTLE; k++) begin
            if (k > 0) begin
               @(posedge clk);
               #1;
            end
            checks++;
            if (int'(bus.i_ref_setup) !== c || bus.busy !== 1'b1 || bus.completed !== 1'b0 ||
                bus.fail !== 1'b0) begin
               errors++;
               $display("FAIL %s settle k=%0d: code=%0d busy=%b completed=%b fail=%b, need code=%0d busy=1 completed=0 fail=0",
                        name, k, bus.i_ref_setup, bus.busy, bus.completed, bus.fail, c);
            end
            if (c == ign_at && k == 1) bus.start = 1'b1;
            if (c == ign_at && k == 2) bus.start = 1'b0;
            if (c == rst_at && k == 1) begin
               rst = 1'b1;
               @(posedge clk);
               #1;
               rst = 1'b0;
               checks++;
               if (bus.i_ref_setup !== 10'd1023 || bus.busy !== 1'b0 ||
                   bus.completed !== 1'b0 || bus.fail !== 1'b0) begin
                  errors++;
                  $display("FAIL %s mid_reset: code=%0d busy=%b completed=%b fail=%b, need 1023/0/0/0",
                           name, bus.i_ref_setup, bus.busy, bus.completed, bus.fail);
               end
               repeat (2 * (SETTLE + 1)) @(posedge clk);
               #1;
               checks++;
               if (bus.i_ref_setup !== 10'd1023 || bus.busy !== 1'b0) begin
                  errors++;
                  $display("FAIL %s idle_after_reset: code=%0d busy=%b, need 1023/0",
                           name, bus.i_ref_setup, bus.busy);
               end
               aborted = 1;
               break;
            end
         end
         if (errors != err0) aborted = 1;
         if (!aborted) begin
            @(posedge clk);
            #1;
         end
      end
      if (rst_at < 0) begin
         checks++;
         if (int'(bus.i_ref_setup) !== exp_code || bus.completed !== exp_done ||
             bus.fail !== !exp_done || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: code=%0d completed=%b fail=%b busy=%b, need code=%0d completed=%b fail=%b busy=0",
                     name, bus.i_ref_setup, bus.completed, bus.fail, bus.busy, exp_code,
                     exp_done, !exp_done);
         end
         // Result must hold while idle.
         repeat (3) @(posedge clk);
         #1;
         checks++;
         if (int'(bus.i_ref_setup) !== exp_code || bus.completed !== exp_done) begin
            errors++;
            $display("FAIL %s hold: code=%0d completed=%b, need code=%0d completed=%b",
                     name, bus.i_ref_setup, bus.completed, exp_code, exp_done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (int'(bus.i_ref_setup) !== int'(I_REF_MAX)) begin
         errors++;
         $display("FAIL reset_code: got %0d need %0d", bus.i_ref_setup, I_REF_MAX);
      end
      checks++;
      if (bus.completed !== 1'b0) begin
         errors++;
         $display("FAIL reset_completed: got %b need 0", bus.completed);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b need 0", bus.busy);
      end
      checks++;
      if (bus.fail !== 1'b0) begin
         errors++;
         $display("FAIL reset_fail: got %b need 0", bus.fail);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      target = 300;
      run_search("nominal_300", -1, -1, 1'b1, 300);
   endtask

   task automatic test_start_ignored();
      target = 300;
      run_search("start_ignored_703", 703, -1, 1'b1, 300);
   endtask

   task automatic test_restart();
      checks++;
      if (bus.completed !== 1'b1) begin
         errors++;
         $display("FAIL restart_pre: completed=%b need 1", bus.completed);
      end
      target = 600;
      run_search("restart_600", -1, -1, 1'b1, 600);
   endtask

   task automatic test_start_and_rst();
      @(negedge clk);
      bus.start = 1'b1;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst       = 1'b0;
      checks++;
      if (bus.i_ref_setup !== 10'd1023 || bus.completed !== 1'b0 || bus.busy !== 1'b0 ||
          bus.fail !== 1'b0) begin
         errors++;
         $display("FAIL start_and_rst: code=%0d completed=%b busy=%b fail=%b, need 1023/0/0/0",
                  bus.i_ref_setup, bus.completed, bus.busy, bus.fail);
      end
   endtask

   task automatic test_above_full();
      target = 1023;
      run_search("above_full_scale", -1, -1, 1'b0, 1023);
   endtask

   task automatic test_below_zero();
      tie_high = 1'b1;
      run_search("below_zero_scale", -1, -1, 1'b0, 0);
      tie_high = 1'b0;
   endtask

   task automatic test_reset_mid();
      target = 300;
      run_search("reset_mid_511", -1, 511, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      target = 300;
      run_search("back_to_back_300", -1, -1, 1'b1, 300);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      tie_high  = 1'b0;
      target    = 0;
      test_reset();
      test_nominal();
      test_start_ignored();
      test_restart();
      test_start_and_rst();
      test_above_full();
      test_below_zero();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
